instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
Requester side of the instruction-memory read interface in the multi-cycle processor. Holds the PC and drives `imem_en` and `imem_addr`. Captures the returned `imem_instruction` into an instruction register after a fixed memory latency, then presents it to the decode/control stage with a valid/ready handshake. Supports PC redirect (branch/jump/reset vector) with flush of any in-flight fetch.

Parameters:
- ADDR_W, 16, PC/address width (word-addressed).
- INSTR_W, 16, instruction width.
- RESET_PC, 16'h0000, PC value after reset.
- MEM_LATENCY, 1, cycles from the `imem_en` cycle to valid `imem_instruction`; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_start  in  1  level; control requests next fetch.
- pc_load  in  1  one-cycle pulse; redirect PC.
- pc_load_value  in  ADDR_W  redirect target.
- imem_en  out  1  read enable to instruction memory.
- imem_addr  out  ADDR_W  read address (equals PC).
- imem_instruction  in  INSTR_W  read data from memory.
- ir_out  out  INSTR_W  captured instruction.
- ir_pc  out  ADDR_W  address the captured instruction came from.
- ir_valid  out  1  `ir_out` holds an unconsumed instruction.
- ir_ready  in  1  decode accepts `ir_out` this cycle.
- busy  out  1  high in ISSUE and WAIT.

Behaviour:
- Reset (`rst`=1 at a clk edge): state=IDLE, pc=RESET_PC, `ir_out`=0, `ir_pc`=0, `ir_valid`=0, wait counter=0. Resulting outputs: `imem_en`=0, `imem_addr`=RESET_PC, `busy`=0.
- Reset mid-operation aborts any fetch; no capture occurs.
- Output decode: `imem_en` = (state==ISSUE). `imem_addr` = pc, combinational from the pc register. `busy` = ISSUE|WAIT.
- FSM states are IDLE, ISSUE, WAIT, HOLD.
  - IDLE: `fetch_start`=1 -> ISSUE.
  - ISSUE: exactly one cycle with `imem_en`=1. Load wait counter with MEM_LATENCY-1. -> WAIT.
  - WAIT: if counter==0, capture `ir_out`<=`imem_instruction`, `ir_pc`<=pc, `ir_valid`<=1, -> HOLD. Otherwise decrement the counter.
  - HOLD: `ir_valid`=1; `ir_out` is stable regardless of memory bus activity. On `ir_ready`=1: `ir_valid`<=0, pc<=pc+1, then -> ISSUE if `fetch_start`=1, else -> IDLE.
- Latency: `fetch_start` sampled in IDLE at cycle 0 -> ISSUE in cycle 1 -> capture at the end of cycle 1+MEM_LATENCY -> `ir_valid`=1 from cycle 2+MEM_LATENCY. With MEM_LATENCY=1, `ir_valid` rises 3 cycles after start.
- Back-to-back throughput: 1 instruction per MEM_LATENCY+2 cycles.
- Redirect: `pc_load`=1 in any state -> pc<=`pc_load_value`, `ir_valid`<=0, state->IDLE.
  - An in-flight fetch (ISSUE/WAIT) is discarded and never captured.
  - `pc_load` in the same cycle as `ir_ready` in HOLD: redirect wins; the instruction counts as consumed and there is no increment.
- Priority: `rst` > `pc_load` > FSM transitions.
- PC arithmetic: modulo 2^ADDR_W; 16'hFFFF+1 -> 16'h0000, no flag.
- `ir_ready` outside HOLD is ignored.
- `fetch_start` in ISSUE/WAIT/HOLD is ignored except at the HOLD exit decision.
- Memory contract: the memory registers `imem_addr` on a clk edge when `imem_en`=1 and holds its output while `imem_en`=0. The unit does not depend on data returned outside the capture cycle.

Decomposition:
- Package `ifu_pkg`: state enum (IDLE, ISSUE, WAIT, HOLD), ADDR_W/INSTR_W defaults, RESET_PC default, MAX_LATENCY=4 constant, wait-counter width (3).
- Parameter check: MEM_LATENCY outside 1..4 is a elaboration error.
- One natural sub-module: `pc_register`. It contains pc with synchronous reset, load and increment, and has load priority over increment.
- The FSM and IR stay in the top module.

Test Plan:
- Reset then fetch with MEM_LATENCY=1, memory preloaded {0:16'h1234, 1:16'hABCD, 2:16'h5678, 3:16'h9ABC}. Hold `fetch_start`=1 and `ir_ready`=1. Expect `ir_out` sequence 1234, ABCD, 5678, 9ABC with `ir_pc` 0,1,2,3. The first `ir_valid` is 3 cycles after start; `imem_en` pulses 1 cycle per fetch.
- Backpressure: hold `ir_ready`=0 in HOLD for 5 cycles. Expect `ir_out`=16'h1234 stable, `ir_valid`=1, `imem_en`=0, pc=0, while the memory output changes. Then `ir_ready`=1 -> pc=1.
- Redirect mid-WAIT: `pc_load`=1 with `pc_load_value`=16'h0003 during WAIT. Expect no capture, state IDLE, `ir_valid`=0. The next fetch returns 16'h9ABC with `ir_pc`=3.
- Wrap-around: `pc_load_value`=16'hFFFF, then fetch and consume. Expect `ir_pc`=16'hFFFF, then pc=16'h0000, and the following fetch addresses 0 (16'h1234).
- Latency sweep MEM_LATENCY=3: expect `ir_valid` 5 cycles after start and capture of the correct word. Redirect + `ir_ready` in the same HOLD cycle -> pc=target, not pc+1.
- Reset mid-operation: `rst`=1 in WAIT. Next cycle all outputs are at reset values (`imem_en`=0, `ir_valid`=0, `ir_out`=0, `imem_addr`=RESET_PC).

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Holds the FSM state encoding and the legal memory-latency bound.
package ifu_pkg;

   localparam int              DEF_ADDR_W   = 16;
   localparam int              DEF_INSTR_W  = 16;
   localparam logic [15:0]     DEF_RESET_PC = 16'h0000;
   localparam int              MAX_LATENCY  = 4;
   localparam int              WCNT_W       = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: control requests, instruction-memory read port and
// the valid/ready handshake towards decode.
interface ifu_if
   import ifu_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int INSTR_W = DEF_INSTR_W
);
   logic               fetch_start;
   logic               pc_load;
   logic [ADDR_W-1:0]  pc_load_value;
   logic               imem_en;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_instruction;
   logic [INSTR_W-1:0] ir_out;
   logic [ADDR_W-1:0]  ir_pc;
   logic               ir_valid;
   logic               ir_ready;
   logic               busy;

   // master is the fetch unit itself; slave is control, memory and decode.
   modport master (
      input  fetch_start, pc_load, pc_load_value, imem_instruction, ir_ready,
      output imem_en, imem_addr, ir_out, ir_pc, ir_valid, busy
   );

   modport slave (
      output fetch_start, pc_load, pc_load_value, imem_instruction, ir_ready,
      input  imem_en, imem_addr, ir_out, ir_pc, ir_valid, busy
   );

endinterface

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter with synchronous reset, redirect load and increment.
// Load takes priority over increment; increment wraps modulo 2^ADDR_W.
module pc_register #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_load_value,
   input  logic              i_inc,
   output logic [ADDR_W-1:0] o_pc
);

   logic [ADDR_W-1:0] r_pc;

   // NOTE: clocked state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst)
         r_pc <= RESET_PC;
      else if (i_load)
         r_pc <= i_load_value;
      else if (i_inc)
         r_pc <= r_pc + ADDR_W'(1);
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues one read per fetch, captures the word after
// MEM_LATENCY cycles and holds it for decode until accepted or redirected.
module instruction_fetch_unit
   import ifu_pkg::*;
#(
   parameter int                ADDR_W      = DEF_ADDR_W,
   parameter int                INSTR_W     = DEF_INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEF_RESET_PC),
   parameter int                MEM_LATENCY = 1
) (
   input  logic clk,
   input  logic rst,
   ifu_if.master bus
);

   if (MEM_LATENCY < 1 || MEM_LATENCY > MAX_LATENCY) begin : g_bad_latency
      $error("instruction_fetch_unit: MEM_LATENCY must be within 1..4");
   end

   state_e              r_state;
   state_e              w_next_state;
   logic [WCNT_W-1:0]   r_wait_cnt;
   logic [INSTR_W-1:0]  r_ir_out;
   logic [ADDR_W-1:0]   r_ir_pc;
   logic                r_ir_valid;
   logic [ADDR_W-1:0]   w_pc;
   logic                w_capture;
   logic                w_consume;

   assign w_capture = (r_state == WAIT) && (r_wait_cnt == '0);
   assign w_consume = (r_state == HOLD) && bus.ir_ready;

   pc_register #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_register (
      .clk          (clk),
      .rst          (rst),
      .i_load       (bus.pc_load),
      .i_load_value (bus.pc_load_value),
      .i_inc        (w_consume),
      .o_pc         (w_pc)
   );

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_next_state;
   end

   // NOTE: default assignment first so no path through this block infers a latch.
   always_comb begin
      w_next_state = r_state;
      if (bus.pc_load) begin
         w_next_state = IDLE;
      end else begin
         unique case (r_state)
            IDLE:  if (bus.fetch_start) w_next_state = ISSUE;
            ISSUE: w_next_state = WAIT;
            WAIT:  if (w_capture) w_next_state = HOLD;
            HOLD:  if (bus.ir_ready) w_next_state = bus.fetch_start ? ISSUE : IDLE;
         endcase
      end
   end

   always_comb begin
      bus.imem_en   = (r_state == ISSUE);
      bus.busy      = (r_state == ISSUE) || (r_state == WAIT);
      bus.imem_addr = w_pc;
      bus.ir_out    = r_ir_out;
      bus.ir_pc     = r_ir_pc;
      bus.ir_valid  = r_ir_valid;
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_wait_cnt <= '0;
      else if (r_state == ISSUE)
         r_wait_cnt <= WCNT_W'(MEM_LATENCY - 1);
      else if (r_state == WAIT && r_wait_cnt != '0)
         r_wait_cnt <= r_wait_cnt - WCNT_W'(1);
   end

   // A redirect discards any in-flight fetch, so it blocks capture as well.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ir_out   <= '0;
         r_ir_pc    <= '0;
         r_ir_valid <= 1'b0;
      end else if (bus.pc_load) begin
         r_ir_valid <= 1'b0;
      end else if (w_capture) begin
         r_ir_out   <= bus.imem_instruction;
         r_ir_pc    <= w_pc;
         r_ir_valid <= 1'b1;
      end else if (w_consume) begin
         r_ir_valid <= 1'b0;
      end
   end

endmodule
